// File: rtl/slice_writeback_buffer_pkg.sv
// Shared constants, state encoding and line helpers for slice_writeback_buffer.
package slice_buf_pkg;
  localparam int LINE_W = 25;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int CNT_W  = ADDR_W + 1;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Running XOR used for the optional frame checksum.
  function automatic line_t line_fold(input line_t acc, input line_t v);
    return acc ^ v;
  endfunction
endpackage

// File: rtl/slice_writeback_buffer_ram.sv
// Frame storage for slice_writeback_buffer: DEPTH x LINE_W, synchronous write,
// asynchronous read, no reset (contents are only read after being written).
module slice_ram
  import slice_buf_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [LINE_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [LINE_W-1:0] o_rdata
);
  logic [LINE_W-1:0] r_mem [DEPTH];

  // Line store.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/slice_writeback_buffer.sv
// Captures one frame of encoder slice lines, then drains it in index order over
// valid/ready. Optional XOR checksum of the captured frame under `CHECKSUM_EN.
module slice_writeback_buffer
  import slice_buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic [LINE_W-1:0] write_value,
  input  logic              donee,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [LINE_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              frame_done,
  output logic              overflow,
`ifdef CHECKSUM_EN
  output logic [LINE_W-1:0] checksum,
`endif
  output logic              busy
);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_frame_done;
  logic              r_overflow;
  logic              w_store;
  logic              w_drop;
  logic              w_xfer;
  logic              w_last;
  logic              w_last_idx;
  logic [LINE_W-1:0] w_rdata;

  assign w_last_idx = ({1'b0, r_rptr} == (r_count - CNT_ONE));

  slice_ram u_ram (
    .clk     (clk),
    .i_we    (w_store),
    .i_waddr (r_wptr),
    .i_wdata (write_value),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus store/drop/transfer strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_store     = 1'b0;
    w_drop      = 1'b0;
    w_xfer      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (write_enable) begin
          w_store     = 1'b1;
          w_state_nxt = S_FILL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FILL: begin
        // A full frame leaves FILL one cycle after the last store; writes in that cycle are lost.
        if (r_count == CNT_FULL) begin
          w_drop      = write_enable;
          w_state_nxt = S_DRAIN;
        end else begin
          w_store = write_enable;
          if (donee) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_FILL;
          end
        end
      end
      S_DRAIN: begin
        w_drop = write_enable;
        w_xfer = out_ready;
        w_last = out_ready & w_last_idx;
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Pointers, fill count, completion pulse and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr       <= {ADDR_W{1'b0}};
      r_rptr       <= {ADDR_W{1'b0}};
      r_count      <= {CNT_W{1'b0}};
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_done <= w_last;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_last) begin
        r_wptr  <= {ADDR_W{1'b0}};
        r_rptr  <= {ADDR_W{1'b0}};
        r_count <= {CNT_W{1'b0}};
      end else begin
        if (w_store) begin
          r_wptr  <= r_wptr + PTR_ONE;
          r_count <= r_count + CNT_ONE;
        end
        if (w_xfer) begin
          r_rptr <= r_rptr + PTR_ONE;
        end
      end
    end
  end

`ifdef CHECKSUM_EN
  logic [LINE_W-1:0] r_checksum;

  // Frame checksum: restarts with the first line, holds through frame_done, then clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_checksum <= {LINE_W{1'b0}};
    end else if (w_store) begin
      r_checksum <= (r_state == S_IDLE) ? write_value : line_fold(r_checksum, write_value);
    end else if (r_state == S_IDLE) begin
      r_checksum <= {LINE_W{1'b0}};
    end
  end

  assign checksum = r_checksum;
`endif

  assign out_valid  = (r_state == S_DRAIN);
  assign out_data   = out_valid ? w_rdata : {LINE_W{1'b0}};
  assign out_index  = r_rptr;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;
  assign busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_slice_writeback_buffer.sv
// Self-checking bench for slice_writeback_buffer: table of frame vectors plus
// reset, idle-donee and checksum sequences; a scoreboard checks every drained line.
module tb_slice_writeback_buffer;
  import slice_buf_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              write_enable = 1'b0;
  logic [LINE_W-1:0] write_value = {LINE_W{1'b0}};
  logic              donee = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [LINE_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              frame_done;
  logic              overflow;
  logic              busy;
`ifdef CHECKSUM_EN
  logic [LINE_W-1:0] checksum;
`endif

  slice_writeback_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .write_value  (write_value),
    .donee        (donee),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_index    (out_index),
    .frame_done   (frame_done),
    .overflow     (overflow),
`ifdef CHECKSUM_EN
    .checksum     (checksum),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] idx;
    logic [LINE_W-1:0] data;
  } exp_t;

  // n lines written as base + i*mult; dmode 0 none, 1 donee after last write, 2 donee with it;
  // rmode 0 ready=1, 1 ready 1,0,0..., 2 random; ovf writes in DRAIN; exp_ovf sticky flag afterwards.
  typedef struct {
    int n;
    int base;
    int mult;
    int dmode;
    int rmode;
    int ovf;
    int exp_ovf;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   n_cmp = 0;
  int   n_err = 0;
  int   fd_count = 0;
  int   vcyc = 0;
  int   rcnt = 0;
  int   rmode = 0;
  logic [LINE_W-1:0] chk_at_fd = {LINE_W{1'b0}};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rcnt++;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((rcnt % 3) == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Output monitor: every valid cycle must present the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_done) begin
        fd_count++;
        chk("valid_low_on_done", 32'(out_valid), 32'd0);
`ifdef CHECKSUM_EN
        chk_at_fd = checksum;
`endif
      end
      if (out_valid) begin
        vcyc++;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          chk("out_index", 32'(out_index), 32'(sb[0].idx));
          chk("out_data", 32'(out_data), 32'(sb[0].data));
          if (out_ready) begin
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic run_frame(input vec_t v, input string tag);
    int fd0;
    int v0;
    int guard;
    int novf;
    int nexp;
    fd0   = fd_count;
    v0    = vcyc;
    rmode = v.rmode;
    nexp  = (v.n < DEPTH) ? v.n : DEPTH;
    for (int i = 0; i < v.n; i++) begin
      step();
      write_enable = 1'b1;
      write_value  = LINE_W'(v.base + i * v.mult);
      donee        = (v.dmode == 2) && (i == v.n - 1);
      if (i < DEPTH) begin
        sb.push_back('{idx: ADDR_W'(i), data: LINE_W'(v.base + i * v.mult)});
      end
    end
    step();
    write_enable = 1'b0;
    donee        = (v.dmode == 1);
    step();
    donee = 1'b0;
    guard = 0;
    novf  = 0;
    while ((sb.size() != 0 || fd_count == fd0) && guard < 3000) begin
      step();
      guard++;
      if (v.ovf != 0 && out_valid && novf < 3 && sb.size() > 4) begin
        write_enable = 1'b1;
        write_value  = 25'h1FFFFFF;
        novf++;
      end else begin
        write_enable = 1'b0;
      end
    end
    write_enable = 1'b0;
    chk({tag, "_timeout"}, 32'(guard < 3000), 32'd1);
    step();
    step();
    chk({tag, "_frame_done_pulses"}, 32'(fd_count - fd0), 32'd1);
    chk({tag, "_overflow"}, 32'(overflow), 32'(v.exp_ovf));
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    if (v.rmode == 0) begin
      chk({tag, "_valid_cycles"}, 32'(vcyc - v0), 32'(nexp));
    end
  endtask

  initial begin
    vec_t vr;
    int   guard;
    int   fd0;
    int   v0;

    tbl[0] = '{64, 0,         1,       0, 0, 0, 0};
    tbl[1] = '{64, 'h0A5A5A5, 'h13579, 0, 1, 0, 0};
    tbl[2] = '{10, 'h100,     7,       1, 0, 0, 0};
    tbl[3] = '{1,  'h0ABCDEF, 1,       1, 2, 0, 0};
    tbl[4] = '{64, 'h55555,   'h2468,  2, 2, 0, 0};
    tbl[5] = '{20, 'h77,      3,       2, 1, 0, 0};
    tbl[6] = '{64, 'h1000,    1,       0, 0, 1, 1};
    tbl[7] = '{65, 'h40,      5,       0, 1, 0, 1};

    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    step();
    rst = 1'b1;

    // donee while idle with nothing captured must be ignored.
    v0 = vcyc;
    donee = 1'b1;
    step();
    step();
    step();
    chk("idle_donee_busy", 32'(busy), 32'd0);
    chk("idle_donee_valid", 32'(vcyc - v0), 32'd0);
    donee = 1'b0;

    for (int t = 0; t < 8; t++) begin
      run_frame(tbl[t], $sformatf("vec%0d", t));
    end

    // Reset in the middle of a drain.
    rmode = 0;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      write_enable = 1'b1;
      write_value  = LINE_W'(i * 3 + 11);
      sb.push_back('{idx: ADDR_W'(i), data: LINE_W'(i * 3 + 11)});
    end
    step();
    write_enable = 1'b0;
    guard = 0;
    while (!(out_valid && out_index == ADDR_W'(20)) && guard < 500) begin
      step();
      guard++;
    end
    chk("mid_drain_reach20", 32'(guard < 500), 32'd1);
    fd0 = fd_count;
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_out_index", 32'(out_index), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    sb.delete();
    step();
    step();
    chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b1;
    step();
    chk("mid_rst_no_done_pulse", 32'(fd_count - fd0), 32'd0);
    vr = '{64, 'h1F0F0F, 'h101, 0, 0, 0, 0};
    run_frame(vr, "post_rst");

`ifdef CHECKSUM_EN
    vr = '{2, 1, 2, 1, 0, 0, 0};
    run_frame(vr, "cksum");
    chk("checksum_at_done", 32'(chk_at_fd), 32'h0000002);
    chk("checksum_cleared", 32'(checksum), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
